// File: rtl/matmul_pkg.sv
// matmul_pkg: definitions shared by the matrix-multiply sequencer and datapath.
//   seq_state_e  - sequencer state encoding
//   DEF_M/N/P    - default matrix dimensions
//   addr_width() - bits needed to index 'depth' entries (at least 1)
package matmul_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLR,
        RD,
        DRAIN,
        WR,
        SRD,
        SOUT,
        DONE
    } seq_state_e;

    localparam int unsigned DEF_M = 8;
    localparam int unsigned DEF_N = 8;
    localparam int unsigned DEF_P = 8;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: handshake and datapath-control bundle of the sequencer.
//   master - sequencer side (drives handshake readies/valids, memory and MAC controls)
//   slave  - datapath / environment side
// Signals: start, in_valid/in_ready, out_valid/out_ready, m{1,2,3}{w,r}EN,
//          addr1..addr3 (AW bits), mult_rst, mult_ld, busy, done.
interface matmul_sequencer_if #(
    parameter int unsigned AW = 6
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          m1wEN;
    logic          m2wEN;
    logic          m3wEN;
    logic          m1rEN;
    logic          m2rEN;
    logic          m3rEN;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [AW-1:0] addr3;
    logic          mult_rst;
    logic          mult_ld;
    logic          busy;
    logic          done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, out_valid,
        output m1wEN, m2wEN, m3wEN, m1rEN, m2rEN, m3rEN,
        output addr1, addr2, addr3,
        output mult_rst, mult_ld, busy, done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, out_valid,
        input  m1wEN, m2wEN, m3wEN, m1rEN, m2rEN, m3rEN,
        input  addr1, addr2, addr3,
        input  mult_rst, mult_ld, busy, done
    );
endinterface

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: row-major address arithmetic for the sequencer.
//   i, j, k  - row of A/C, column of B/C, accumulation index
//   s        - stream counter
//   a_addr   - A[i][k] = i*N+k      b_addr - B[k][j] = k*P+j
//   c_addr   - C[i][j] = i*P+j      s_addr - stream address
// All results truncated to AW bits.
module matmul_addr_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned P  = 8,
    parameter int unsigned AW = 6,
    parameter int unsigned IW = 3,
    parameter int unsigned JW = 3,
    parameter int unsigned KW = 3,
    parameter int unsigned SW = 6
) (
    input  logic [IW-1:0] i,
    input  logic [JW-1:0] j,
    input  logic [KW-1:0] k,
    input  logic [SW-1:0] s,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] c_addr,
    output logic [AW-1:0] s_addr
);
    assign a_addr = AW'(32'(i) * N + 32'(k));
    assign b_addr = AW'(32'(k) * P + 32'(j));
    assign c_addr = AW'(32'(i) * P + 32'(j));
    assign s_addr = AW'(32'(s));
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads A (MxN) into memory 1 and B (NxP) into memory 2 from a
// byte-serial handshake, runs the multiply-accumulate schedule writing C=A*B to
// memory 3, then streams C out over the output handshake.
// Ports: clk, reset (async, active-low), bus (matmul_sequencer_if.master),
//        perf_cycles (only with MATMUL_SEQ_PERF_CNT_EN: cycles from LOAD_A to DONE).
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned M  = DEF_M,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned P  = DEF_P,
    parameter int unsigned AW = 6
) (
    input  logic clk,
    input  logic reset,
    matmul_sequencer_if.master bus
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles
`endif
);
    localparam int unsigned MN = M * N;
    localparam int unsigned NP = N * P;
    localparam int unsigned MP = M * P;
    localparam int unsigned LW = addr_width((MN > NP) ? MN : NP);
    localparam int unsigned IW = addr_width(M);
    localparam int unsigned JW = addr_width(P);
    localparam int unsigned KW = addr_width(N);
    localparam int unsigned SW = addr_width(MP);

    seq_state_e    state, state_n;
    logic [LW-1:0] ld_cnt, ld_n;
    logic [IW-1:0] i_q, i_n;
    logic [JW-1:0] j_q, j_n;
    logic [KW-1:0] k_q, k_n;
    logic [SW-1:0] s_q, s_n;

    logic          rdy_a, rdy_b, rdy_a_n, rdy_b_n;
    logic          accept;
    logic          out_valid_n, m1r_n, m3w_n, m3r_n, mult_rst_n, mult_ld_n, busy_n, done_n;
    logic [AW-1:0] addr1_n, addr2_n, addr3_n;
    logic [AW-1:0] a_addr, b_addr, c_addr, s_addr;

    assign bus.in_ready = rdy_a | rdy_b;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.m1wEN    = accept & rdy_a;
    assign bus.m2wEN    = accept & rdy_b;

    always_comb begin
        state_n = state;
        ld_n    = ld_cnt;
        i_n     = i_q;
        j_n     = j_q;
        k_n     = k_q;
        s_n     = s_q;
        unique case (state)
            IDLE: if (bus.start) begin
                state_n = LOAD_A;
                ld_n    = '0;
                i_n     = '0;
                j_n     = '0;
                k_n     = '0;
                s_n     = '0;
            end
            LOAD_A: if (accept) begin
                if (ld_cnt == LW'(MN - 1)) begin
                    state_n = LOAD_B;
                    ld_n    = '0;
                end else begin
                    ld_n = ld_cnt + 1'b1;
                end
            end
            LOAD_B: if (accept) begin
                if (ld_cnt == LW'(NP - 1)) begin
                    state_n = CLR;
                    ld_n    = '0;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end else begin
                    ld_n = ld_cnt + 1'b1;
                end
            end
            CLR: state_n = RD;
            RD: begin
                if (k_q == KW'(N - 1)) begin
                    state_n = DRAIN;
                    k_n     = '0;
                end else begin
                    k_n = k_q + 1'b1;
                end
            end
            DRAIN: state_n = WR;
            WR: begin
                state_n = CLR;
                if (j_q == JW'(P - 1)) begin
                    j_n = '0;
                    if (i_q == IW'(M - 1)) begin
                        i_n     = '0;
                        s_n     = '0;
                        state_n = SRD;
                    end else begin
                        i_n = i_q + 1'b1;
                    end
                end else begin
                    j_n = j_q + 1'b1;
                end
            end
            SRD: state_n = SOUT;
            SOUT: if (bus.out_ready) begin
                if (s_q == SW'(MP - 1)) begin
                    state_n = DONE;
                    s_n     = '0;
                end else begin
                    s_n     = s_q + 1'b1;
                    state_n = SRD;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Fed with next-cycle counters so addresses register together with the state.
    matmul_addr_gen #(
        .N (N),
        .P (P),
        .AW(AW),
        .IW(IW),
        .JW(JW),
        .KW(KW),
        .SW(SW)
    ) u_addr_gen (
        .i     (i_n),
        .j     (j_n),
        .k     (k_n),
        .s     (s_n),
        .a_addr(a_addr),
        .b_addr(b_addr),
        .c_addr(c_addr),
        .s_addr(s_addr)
    );

    always_comb begin
        rdy_a_n     = (state_n == LOAD_A);
        rdy_b_n     = (state_n == LOAD_B);
        m1r_n       = (state_n == RD);
        m3w_n       = (state_n == WR);
        m3r_n       = (state_n == SRD);
        mult_rst_n  = (state_n == CLR);
        // Memory read latency is one cycle: accumulate in the cycle after each RD.
        mult_ld_n   = (state == RD);
        out_valid_n = (state_n == SOUT);
        busy_n      = (state_n != IDLE);
        done_n      = (state_n == DONE);
        addr1_n     = rdy_a_n ? AW'(ld_n) : (m1r_n ? a_addr : '0);
        addr2_n     = rdy_b_n ? AW'(ld_n) : (m1r_n ? b_addr : '0);
        addr3_n     = m3w_n ? c_addr :
                      ((state_n == SRD || state_n == SOUT) ? s_addr : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ld_cnt        <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            s_q           <= '0;
            rdy_a         <= 1'b0;
            rdy_b         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.m1rEN     <= 1'b0;
            bus.m2rEN     <= 1'b0;
            bus.m3wEN     <= 1'b0;
            bus.m3rEN     <= 1'b0;
            bus.addr1     <= '0;
            bus.addr2     <= '0;
            bus.addr3     <= '0;
            bus.mult_rst  <= 1'b0;
            bus.mult_ld   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_n;
            ld_cnt        <= ld_n;
            i_q           <= i_n;
            j_q           <= j_n;
            k_q           <= k_n;
            s_q           <= s_n;
            rdy_a         <= rdy_a_n;
            rdy_b         <= rdy_b_n;
            bus.out_valid <= out_valid_n;
            bus.m1rEN     <= m1r_n;
            bus.m2rEN     <= m1r_n;
            bus.m3wEN     <= m3w_n;
            bus.m3rEN     <= m3r_n;
            bus.addr1     <= addr1_n;
            bus.addr2     <= addr2_n;
            bus.addr3     <= addr3_n;
            bus.mult_rst  <= mult_rst_n;
            bus.mult_ld   <= mult_ld_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
        end
    end

`ifdef MATMUL_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (state == IDLE) begin
            if (bus.start) perf_cycles <= '0;
        end else begin
            perf_cycles <= perf_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer with M=N=P=2: a behavioural datapath (memories and
// accumulator) around the sequencer, a scoreboard of C elements computed from the
// loaded matrices, and directed scenarios for load throttling, backpressure,
// asynchronous reset and start while busy.
module tb_matmul_sequencer;
    localparam int unsigned M  = 2;
    localparam int unsigned N  = 2;
    localparam int unsigned P  = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned MN = M * N;
    localparam int unsigned NP = N * P;
    localparam int unsigned MP = M * P;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.AW(AW)) bus ();
    logic [7:0] data_in;
`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    matmul_sequencer #(
        .M (M),
        .N (N),
        .P (P),
        .AW(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef MATMUL_SEQ_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    // Behavioural datapath
    logic [7:0]  mem1 [2**AW];
    logic [7:0]  mem2 [2**AW];
    logic [31:0] mem3 [2**AW];
    logic [7:0]  rd1, rd2;
    logic [31:0] acc, data_out;

    always @(posedge clk) begin
        if (bus.m1wEN) mem1[bus.addr1] <= data_in;
        if (bus.m2wEN) mem2[bus.addr2] <= data_in;
        if (bus.m1rEN) rd1 <= mem1[bus.addr1];
        if (bus.m2rEN) rd2 <= mem2[bus.addr2];
        if (bus.mult_rst)     acc <= '0;
        else if (bus.mult_ld) acc <= acc + 32'(rd1) * 32'(rd2);
        if (bus.m3wEN) mem3[bus.addr3] <= acc;
        if (bus.m3rEN) data_out <= mem3[bus.addr3];
    end

    int n_tests   = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int done_base = 0;

    typedef struct {
        int unsigned idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mat_a [MN];
    logic [7:0] mat_b [NP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {bus.in_ready, bus.out_valid, bus.m1wEN, bus.m2wEN, bus.m3wEN,
                              bus.m1rEN, bus.m2rEN, bus.m3rEN, bus.mult_rst, bus.mult_ld,
                              bus.busy, bus.done}, 0);
        check({tag, "_addr"}, {bus.addr1, bus.addr2, bus.addr3}, 0);
`ifdef MATMUL_SEQ_PERF_CNT_EN
        check({tag, "_perf"}, perf_cycles, 0);
`endif
    endtask

    // Output monitor: each accepted element is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done) done_cnt++;
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("c_addr", bus.addr3, e.idx);
                check("c_data", data_out, e.val);
            end
        end
    end

    task automatic push_expected();
        exp_t        e;
        logic [31:0] sum;
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < P; j++) begin
                sum = '0;
                for (int unsigned k = 0; k < N; k++)
                    sum += 32'(mat_a[i*N+k]) * 32'(mat_b[k*P+j]);
                e.idx = i * P + j;
                e.val = sum;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_job();
        done_base = done_cnt;
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        data_in      = 8'hEE;
        @(negedge clk);
        check("start_no_accept", {bus.in_ready, bus.m1wEN}, 0);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic load_mats(input bit toggle);
        int unsigned idx;
        bit          v;
        idx = 0;
        v   = 1'b1;
        while (idx < MN) begin
            bus.in_valid = v;
            data_in      = mat_a[idx];
            @(negedge clk);
            if (toggle) begin
                check("lda_ready", bus.in_ready, 1);
                check("lda_wen", bus.m1wEN, v);
                check("lda_addr", bus.addr1, idx);
            end
            if (v) idx++;
            if (toggle) v = !v;
            @(posedge clk); #1;
        end
        idx = 0;
        while (idx < NP) begin
            bus.in_valid = 1'b1;
            data_in      = mat_b[idx];
            @(negedge clk);
            check("ldb_wen", {bus.m1wEN, bus.m2wEN}, 1);
            check("ldb_addr", bus.addr2, idx);
            idx++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        push_expected();
    endtask

    // Entered in the CLR cycle; counts CLR entry through the last WR.
    task automatic measure_compute();
        int unsigned cyc, wr;
        bit          seen;
`ifdef MATMUL_SEQ_PERF_CNT_EN
        logic [31:0] p0, p1;
        p0 = '0;
        p1 = '0;
`endif
        cyc  = 0;
        wr   = 0;
        seen = 1'b0;
        bus.in_valid = 1'b1;  // stray bytes outside the load states must be dropped
        for (int unsigned t = 0; t < 400 && wr < MP; t++) begin
            @(negedge clk);
            check("no_load_wen", {bus.m1wEN, bus.m2wEN}, 0);
            if (bus.mult_rst && !seen) begin
                seen = 1'b1;
`ifdef MATMUL_SEQ_PERF_CNT_EN
                p0 = perf_cycles;
`endif
            end
            if (seen) cyc++;
            if (bus.m3wEN) begin
                wr++;
`ifdef MATMUL_SEQ_PERF_CNT_EN
                p1 = perf_cycles;
`endif
            end
        end
        bus.in_valid = 1'b0;
        check("compute_writes", wr, MP);
        check("compute_cycles", cyc, MP * (N + 3));
`ifdef MATMUL_SEQ_PERF_CNT_EN
        check("perf_compute", p1 - p0 + 1, MP * (N + 3));
`endif
    endtask

    task automatic stall_and_poke();
        bit found;
        found = 1'b0;
        for (int unsigned t = 0; t < 100 && !found; t++) begin
            @(negedge clk);
            if (bus.m3rEN && bus.addr3 == AW'(1)) found = 1'b1;
        end
        check("srd1_found", found, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_addr", bus.addr3, 1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        check("busy_at_poke", bus.busy, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_job();
        bit seen;
        seen = 1'b0;
        for (int unsigned t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check("busy_in_done", bus.busy, 1);
            end
        end
        check("done_seen", seen, 1);
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("busy_idle", bus.busy, 0);
        check("done_pulses", done_cnt - done_base, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        bit rd_seen;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        data_in       = '0;
        #2 reset = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Job 1: throttled A load, compute timing, free-running stream
        mat_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        mat_b = '{8'd5, 8'd6, 8'd7, 8'd8};
        start_job();
        load_mats(1'b1);
        measure_compute();
        finish_job();

        // Job 2: backpressure on element 1 and start while busy
        start_job();
        load_mats(1'b0);
        measure_compute();
        stall_and_poke();
        finish_job();

        // Job 3: abandoned by asynchronous reset during RD
        start_job();
        load_mats(1'b0);
        rd_seen = 1'b0;
        for (int unsigned t = 0; t < 50 && !rd_seen; t++) begin
            @(negedge clk);
            if (bus.m1rEN) rd_seen = 1'b1;
        end
        check("rd_reached", rd_seen, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        sb.delete();
        @(negedge clk);
        reset = 1'b1;

        // Job 4: fresh job after reset
        mat_a = '{8'd1, 8'd0, 8'd0, 8'd1};
        mat_b = '{8'd9, 8'd8, 8'd7, 8'd6};
        start_job();
        load_mats(1'b0);
        measure_compute();
        finish_job();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog expired");
    end
endmodule
